// File: rtl/i2c_arb_pkg.sv
// rtl/i2c_arb_pkg.sv - shared types and helpers for the I2C request arbiter
// Contents:
//   state_t          FSM states IDLE/START/BUSY/DONE
//   I2C_WORD_W       engine word width {dev, sub, data}
//   I2C_SUB_W        sub-address width
//   I2C_DAT_W        data byte width
//   SLOT_W, MAX_REQ  per-requester slot width and largest supported requester count
//   get_slot()       extract one {sub, data} slot from a packed request bus
package i2c_arb_pkg;

   typedef enum logic [1:0] {IDLE, START, BUSY, DONE} state_t;

   localparam int I2C_WORD_W = 24;
   localparam int I2C_SUB_W  = 8;
   localparam int I2C_DAT_W  = 8;
   localparam int SLOT_W     = I2C_SUB_W + I2C_DAT_W;
   localparam int MAX_REQ    = 8;

   // The caller zero-extends its bus to MAX_REQ slots so one function serves any NUM_REQ.
   function automatic logic [SLOT_W-1:0] get_slot(input logic [SLOT_W*MAX_REQ-1:0] data,
                                                  input logic [2:0]                idx);
      return data[idx*SLOT_W +: SLOT_W];
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin search, first set bit after ptr
// Ports:
//   req    in   NUM_REQ          request vector
//   ptr    in   $clog2(NUM_REQ)  last granted index; search starts at ptr+1
//   grant  out  $clog2(NUM_REQ)  selected index (0 when valid is low)
//   valid  out  1                any request present
module rr_arbiter #(
   parameter int NUM_REQ = 3
) (
   input  logic [NUM_REQ-1:0]         req,
   input  logic [$clog2(NUM_REQ)-1:0] ptr,
   output logic [$clog2(NUM_REQ)-1:0] grant,
   output logic                       valid
);

   localparam int GW = $clog2(NUM_REQ);

   // Offsets 1..NUM_REQ wrap back to ptr itself last, so the previous winner
   // is only re-granted when nobody else is asking.
   always_comb begin
      int j;
      j     = 0;
      grant = '0;
      valid = 1'b0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         j = (int'(ptr) + k) % NUM_REQ;
         if (!valid && req[j]) begin
            valid = 1'b1;
            grant = GW'(j);
         end
      end
   end

endmodule

// File: rtl/i2c_req_arbiter.sv
// rtl/i2c_req_arbiter.sv - round-robin sharing of one I2C transaction engine
// Optional macro: I2C_ARB_TIMEOUT_EN adds a per-attempt iTICK timeout in START+BUSY.
// Ports:
//   iCLK, iRST_N      clock, asynchronous active-low reset
//   iTICK             engine-side enable strobe (SCL negedge)
//   iREQ/iREQ_WR      per-requester request level and write(1)/read(0)
//   iREQ_DATA         per-requester {sub, data}, slot i at [16i+15:16i]
//   oDONE/oERR/oRDATA completion pulse, error flag, read byte
//   oBUSY/oGRANT      transaction in flight, current/last grant index
//   oGO/oWR/oWDATA    engine command handshake and {DEV_ADDR, sub, data}
//   iEND/iACK/iRDATA  engine idle/complete, ACK (0 = acked), read byte
module i2c_req_arbiter
   import i2c_arb_pkg::*;
#(
   parameter int         NUM_REQ       = 3,
   parameter logic [7:0] DEV_ADDR      = 8'h42,
   parameter int         MAX_RETRY     = 3,
   parameter int         TIMEOUT_TICKS = 1023
) (
   input  logic                         iCLK,
   input  logic                         iRST_N,
   input  logic                         iTICK,
   input  logic [NUM_REQ-1:0]           iREQ,
   input  logic [NUM_REQ-1:0]           iREQ_WR,
   input  logic [16*NUM_REQ-1:0]        iREQ_DATA,
   output logic [NUM_REQ-1:0]           oDONE,
   output logic                         oERR,
   output logic [I2C_DAT_W-1:0]         oRDATA,
   output logic                         oBUSY,
   output logic [$clog2(NUM_REQ)-1:0]   oGRANT,
   output logic                         oGO,
   output logic                         oWR,
   output logic [I2C_WORD_W-1:0]        oWDATA,
   input  logic                         iEND,
   input  logic                         iACK,
   input  logic [I2C_DAT_W-1:0]         iRDATA
);

   localparam int GW = $clog2(NUM_REQ);
   localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

   state_t                  state;
   logic [GW-1:0]           ptr;
   logic [RW-1:0]           retry_cnt;
   logic                    wr_lat;
   logic [GW-1:0]           arb_grant;
   logic                    arb_valid;
   logic [SLOT_W*MAX_REQ-1:0] req_data_ext;
   logic [SLOT_W-1:0]       slot;
   logic                    fin;
   logic                    fin_err;
   logic                    retry;
   logic                    timeout;

   rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
      .req   (iREQ),
      .ptr   (ptr),
      .grant (arb_grant),
      .valid (arb_valid)
   );

   assign req_data_ext = (SLOT_W*MAX_REQ)'(iREQ_DATA);
   assign slot         = get_slot(req_data_ext, 3'(arb_grant));

   // An engine completion in the same tick as the timeout wins over the timeout.
   always_comb begin
      fin     = 1'b0;
      fin_err = 1'b0;
      retry   = 1'b0;
      if (state == BUSY && iTICK && iEND) begin
         if (!iACK) begin
            fin = 1'b1;
         end else if (retry_cnt == RW'(MAX_RETRY)) begin
            fin     = 1'b1;
            fin_err = 1'b1;
         end else begin
            retry = 1'b1;
         end
      end else if (timeout) begin
         fin     = 1'b1;
         fin_err = 1'b1;
      end
   end

`ifdef I2C_ARB_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_TICKS + 1);
   logic [TW-1:0] tick_cnt;
   logic          enter_start;

   assign enter_start = (state == IDLE && iTICK && arb_valid) || retry;
   // Fires on the TIMEOUT_TICKS-th tick of the current attempt.
   assign timeout = iTICK && (state == START || state == BUSY) &&
                    (tick_cnt == TW'(TIMEOUT_TICKS - 1));

   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N)
         tick_cnt <= '0;
      else if (enter_start)
         tick_cnt <= '0;
      else if (iTICK && (state == START || state == BUSY))
         tick_cnt <= tick_cnt + 1'b1;
   end
`else
   assign timeout = 1'b0;
`endif

   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         state     <= IDLE;
         ptr       <= GW'(NUM_REQ - 1);
         retry_cnt <= '0;
         wr_lat    <= 1'b0;
         oDONE     <= '0;
         oERR      <= 1'b0;
         oRDATA    <= '0;
         oBUSY     <= 1'b0;
         oGRANT    <= '0;
         oGO       <= 1'b0;
         oWR       <= 1'b0;
         oWDATA    <= '0;
      end else begin
         oDONE <= '0;
         if (fin) begin
            // Completion outputs are set on entry so they are valid during the DONE cycle.
            oGO    <= 1'b0;
            oWR    <= 1'b0;
            oDONE  <= NUM_REQ'(1) << oGRANT;
            oERR   <= fin_err;
            oRDATA <= iRDATA;
            state  <= DONE;
         end else begin
            case (state)
               IDLE: begin
                  if (iTICK && arb_valid) begin
                     oGRANT <= arb_grant;
                     wr_lat <= iREQ_WR[arb_grant];
                     oWDATA <= {DEV_ADDR, slot};
                     oBUSY  <= 1'b1;
                     state  <= START;
                  end
               end
               START: begin
                  if (iTICK) begin
                     oGO <= 1'b1;
                     oWR <= wr_lat;
                     if (!iEND)
                        state <= BUSY;
                  end
               end
               BUSY: begin
                  if (retry) begin
                     // oWDATA is untouched, so the retry resends the identical word.
                     oGO       <= 1'b0;
                     oWR       <= 1'b0;
                     retry_cnt <= retry_cnt + 1'b1;
                     state     <= START;
                  end
               end
               DONE: begin
                  ptr       <= oGRANT;
                  retry_cnt <= '0;
                  oBUSY     <= 1'b0;
                  state     <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_i2c_req_arbiter.sv
// tb/tb_i2c_req_arbiter.sv - self-checking bench for i2c_req_arbiter
module tb_i2c_req_arbiter;

   localparam int NR = 3;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          tick = 1'b0;
   logic [1:0]    tdiv = 2'd0;
   logic [NR-1:0] req, req_wr;
   logic [47:0]   req_data;
   logic [NR-1:0] done;
   logic          err, busy, go, wr;
   logic [7:0]    rdata;
   logic [1:0]    grant;
   logic [23:0]   wdata;
   logic          eng_end, eng_ack;
   logic [7:0]    eng_rdata;

   i2c_req_arbiter #(.NUM_REQ(NR), .DEV_ADDR(8'h42), .MAX_RETRY(3), .TIMEOUT_TICKS(16)) dut (
      .iCLK(clk), .iRST_N(rst_n), .iTICK(tick),
      .iREQ(req), .iREQ_WR(req_wr), .iREQ_DATA(req_data),
      .oDONE(done), .oERR(err), .oRDATA(rdata), .oBUSY(busy), .oGRANT(grant),
      .oGO(go), .oWR(wr), .oWDATA(wdata),
      .iEND(eng_end), .iACK(eng_ack), .iRDATA(eng_rdata)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      tdiv <= tdiv + 2'd1;
      tick <= (tdiv == 2'd3);
   end

   // Engine model: starts on a GO rising edge seen at a tick, busy 4 ticks,
   // NACKs the first cfg_nacks attempts of each transaction.
   int          cfg_nacks = 0;
   logic        cfg_hang = 1'b0;
   logic [7:0]  cfg_rdata = 8'h00;
   logic        go_prev;
   int          bcnt, nack_given;
   logic [23:0] eng_word;
   logic        eng_wr;

   assign eng_rdata = cfg_rdata;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         eng_end <= 1'b1; eng_ack <= 1'b0; go_prev <= 1'b0; bcnt <= 0; nack_given <= 0;
      end else begin
         if (done != '0) nack_given <= 0;
         if (tick) begin
            go_prev <= go;
            if (go && !go_prev && eng_end) begin
               eng_end <= 1'b0; bcnt <= 3; eng_word <= wdata; eng_wr <= wr;
            end else if (!eng_end && !cfg_hang) begin
               if (bcnt == 0) begin
                  eng_end <= 1'b1;
                  if (nack_given < cfg_nacks) begin
                     eng_ack <= 1'b1; nack_given <= nack_given + 1;
                  end else begin
                     eng_ack <= 1'b0;
                  end
               end else begin
                  bcnt <= bcnt - 1;
               end
            end
         end
      end
   end

   typedef struct {
      int          idx;
      logic        err;
      logic [7:0]  rdata;
      logic        chk_rd;
      logic [23:0] word;
      logic        wr;
      int          gos;
      int          ticks;
   } exp_t;

   typedef struct {
      int          idx;
      logic        wr;
      logic [15:0] data;
      int          nacks;
      logic [7:0]  rd;
      logic        exp_err;
      int          exp_gos;
   } vec_t;

   exp_t sbq[$];
   int   checks = 0, errors = 0, done_seen = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic exp_t mk_exp(input int idx, input logic e, input logic [7:0] rd,
                                   input logic chk, input logic [23:0] w, input logic wrb,
                                   input int gos, input int ticks);
      exp_t x;
      x.idx = idx; x.err = e; x.rdata = rd; x.chk_rd = chk; x.word = w;
      x.wr = wrb; x.gos = gos; x.ticks = ticks;
      return x;
   endfunction

   // Monitor: accumulates per-transaction observations, compares at each oDONE.
   initial begin
      exp_t e;
      logic go_q;
      int   go_cnt, gap_cnt, tbusy;
      logic wr_seen;
      go_q = 0; go_cnt = 0; gap_cnt = 0; tbusy = 0; wr_seen = 0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            go_q = 0; go_cnt = 0; gap_cnt = 0; tbusy = 0; wr_seen = 0;
         end else begin
            if (go && !go_q) go_cnt++;
            go_q = go;
            if (wr) wr_seen = 1'b1;
            if (!eng_end && !go && !cfg_hang) gap_cnt++;
            if (tick && busy && done == '0) tbusy++;
            if (done != '0) begin
               done_seen++;
               check("done_onehot", $countones(done), 1);
               if (sbq.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL done_unexpected actual=%0h required=none", done);
               end else begin
                  e = sbq.pop_front();
                  check("done_idx", 32'(done), 32'(1) << e.idx);
                  check("err", 32'(err), 32'(e.err));
                  if (e.chk_rd) check("rdata", 32'(rdata), 32'(e.rdata));
                  check("wdata", 32'(eng_word), 32'(e.word));
                  check("eng_wr", 32'(eng_wr), 32'(e.wr));
                  check("wr_seen", 32'(wr_seen), 32'(e.wr));
                  check("go_count", go_cnt, e.gos);
                  check("go_gap", gap_cnt, 0);
                  if (e.ticks >= 0) check("timeout_ticks", tbusy, e.ticks);
               end
               go_cnt = 0; gap_cnt = 0; tbusy = 0; wr_seen = 0;
            end
         end
      end
   end

   task automatic wait_done(input string name);
      logic ok;
      ok = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         if (done != '0) begin ok = 1'b1; break; end
      end
      check(name, 32'(ok), 1);
   endtask

   task automatic wait_eng_busy(input string name);
      logic ok;
      ok = 1'b0;
      for (int c = 0; c < 2000; c++) begin
         @(negedge clk);
         if (!eng_end && go) begin ok = 1'b1; break; end
      end
      check(name, 32'(ok), 1);
   endtask

   vec_t vecs[6];

   initial begin
      int base, cnt;
      logic ok;
      req = '0; req_wr = '0; req_data = '0;
      vecs[0] = '{0, 1'b1, 16'h1204, 0,  8'h00, 1'b0, 1};
      vecs[1] = '{1, 1'b0, 16'h0A00, 0,  8'h77, 1'b0, 1};
      vecs[2] = '{2, 1'b1, 16'h3355, 2,  8'h00, 1'b0, 3};
      vecs[3] = '{0, 1'b1, 16'hBEEF, 3,  8'h00, 1'b0, 4};
      vecs[4] = '{1, 1'b1, 16'h0102, 99, 8'h00, 1'b1, 4};
      vecs[5] = '{2, 1'b0, 16'hFF01, 0,  8'hA5, 1'b0, 1};

      repeat (5) @(negedge clk);
      check("rst_done", 32'(done), 0);
      check("rst_err", 32'(err), 0);
      check("rst_rdata", 32'(rdata), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_grant", 32'(grant), 0);
      check("rst_go", 32'(go), 0);
      check("rst_wr", 32'(wr), 0);
      check("rst_wdata", 32'(wdata), 0);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);

      for (int i = 0; i < 6; i++) begin
         cfg_nacks = vecs[i].nacks;
         cfg_rdata = vecs[i].rd;
         req_wr[vecs[i].idx] = vecs[i].wr;
         req_data[16*vecs[i].idx +: 16] = vecs[i].data;
         sbq.push_back(mk_exp(vecs[i].idx, vecs[i].exp_err, vecs[i].rd, !vecs[i].wr,
                              {8'h42, vecs[i].data}, vecs[i].wr, vecs[i].exp_gos, -1));
         req[vecs[i].idx] = 1'b1;
         wait_done("vec_done");
         req = '0;
         repeat (6) @(negedge clk);
      end

      // Requester drops iREQ and changes its data mid-transaction.
      cfg_nacks = 0;
      req_wr[1] = 1'b1;
      req_data[31:16] = 16'h5A5A;
      sbq.push_back(mk_exp(1, 1'b0, 8'h00, 1'b0, 24'h425A5A, 1'b1, 1, -1));
      req[1] = 1'b1;
      wait_eng_busy("drop_busy");
      req[1] = 1'b0;
      req_data[31:16] = 16'hFFFF;
      wait_done("drop_done");
      repeat (6) @(negedge clk);

      // Reset while BUSY: GO falls immediately, no DONE follows.
      req_wr[2] = 1'b1;
      req[2] = 1'b1;
      wait_eng_busy("rst_busy_wait");
      base = done_seen;
      #2 rst_n = 1'b0;
      #1;
      check("rst_mid_go", 32'(go), 0);
      check("rst_mid_busy", 32'(busy), 0);
      repeat (3) @(negedge clk);
      req = '0;
      rst_n = 1'b1;
      repeat (60) @(negedge clk);
      check("rst_mid_no_done", done_seen - base, 0);

      // All three requesting continuously: strict rotation starting at 0.
      req_wr = 3'b111;
      req_data = {16'h3003, 16'h2002, 16'h1001};
      for (int r = 0; r < 6; r++)
         sbq.push_back(mk_exp(r % 3, 1'b0, 8'h00, 1'b0,
                              {8'h42, 4'(r % 3 + 1), 8'h00, 4'(r % 3 + 1)}, 1'b1, 1, -1));
      req = 3'b111;
      cnt = 0;
      for (int c = 0; c < 6000 && cnt < 6; c++) begin
         @(negedge clk);
         if (done != '0) cnt++;
      end
      req = '0;
      check("rr_count", cnt, 6);
      repeat (6) @(negedge clk);

      // Engine never completes.
      cfg_hang = 1'b1;
      req_data[15:0] = 16'h00C3;
`ifdef I2C_ARB_TIMEOUT_EN
      sbq.push_back(mk_exp(0, 1'b1, 8'h00, 1'b0, 24'h4200C3, 1'b1, 1, 16));
      req[0] = 1'b1;
      wait_done("timeout_done");
      req = '0;
`else
      base = done_seen;
      req[0] = 1'b1;
      repeat (400) @(negedge clk);
      check("hang_no_done", done_seen - base, 0);
      check("hang_busy", 32'(busy), 1);
      rst_n = 1'b0;
      req = '0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
`endif
      repeat (20) @(negedge clk);
      check("sb_empty", sbq.size(), 0);
      ok = 1'b1;
      if (ok) $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
